parking_floor_allocator: RTL and testbench

Sequential controller that owns per-floor slot occupancy for the three-floor car park and sequences the entry and exit barriers. It arbitrates between the entry gate and the exit gate and picks a floor with a free slot for each entering car. It drives the 2-bit floor index and the full flag consumed by the floor one-hot decoder and the display logic.

---
 rtl/parking_floor_allocator_if.sv | 29 ++
 rtl/parking_floor_allocator.sv | 228 ++++++++++++++++++++++
 tb/tb_parking_floor_allocator.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/parking_floor_allocator_if.sv
// Gate request/response bundle between the car-park gate hardware and the floor allocator.
// master = gate side (drives requests), slave = allocator (drives acks, barrier and occupancy).
interface parking_floor_allocator_if #(
  parameter int CNT_W = 3
);
  logic             entry_req;
  logic             exit_req;
  logic [1:0]       exit_floor;
  logic             entry_ack;
  logic             entry_nack;
  logic             exit_ack;
  logic             exit_err;
  logic             barrier_open;
  logic [1:0]       floor;
  logic             full;
  logic [CNT_W-1:0] occ0;
  logic [CNT_W-1:0] occ1;
  logic [CNT_W-1:0] occ2;

  modport master (
    output entry_req, exit_req, exit_floor,
    input  entry_ack, entry_nack, exit_ack, exit_err, barrier_open, floor, full, occ0, occ1, occ2
  );

  modport slave (
    input  entry_req, exit_req, exit_floor,
    output entry_ack, entry_nack, exit_ack, exit_err, barrier_open, floor, full, occ0, occ1, occ2
  );
endinterface

// File: rtl/parking_floor_allocator.sv
// Three-floor car park slot allocator and barrier sequencer.
// Optional macro FLOOR_ROUND_ROBIN_EN: rotate the floor search start after each granted entry.
module parking_floor_allocator #(
  parameter int CAPACITY       = 4,
  parameter int BARRIER_CYCLES = 8
) (
  input logic                     clk,
  input logic                     rst,
  parking_floor_allocator_if.slave bus
);
  localparam int CNT_W = $clog2(CAPACITY + 1);
  localparam int BAR_W = $clog2(BARRIER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CAP_C      = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO_C = {CNT_W{1'b0}};
  localparam logic [BAR_W-1:0] BAR_LOAD_C = BAR_W'(BARRIER_CYCLES);
  localparam logic [BAR_W-1:0] BAR_ONE_C  = BAR_W'(1);
  localparam logic [BAR_W-1:0] BAR_ZERO_C = {BAR_W{1'b0}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    EXIT    = 3'd2,
    OPEN    = 3'd3,
    RELEASE = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] occ_q [3];
  logic [CNT_W-1:0] occ_d [3];
  logic [1:0]       floor_q, floor_d;
  logic [BAR_W-1:0] bar_cnt_q, bar_cnt_d;
  logic             barrier_q, barrier_d;
  logic             entry_ack_q, entry_ack_d;
  logic             entry_nack_q, entry_nack_d;
  logic             exit_ack_q, exit_ack_d;
  logic             exit_err_q, exit_err_d;
  logic             svc_exit_q, svc_exit_d;
  logic [2:0]       avail_s;
  logic             full_s;
  logic [1:0]       start_s;
  logic [1:0]       pick_s;
  logic             exit_ok_s;

  // First floor with a free slot, scanning upward from start and wrapping after floor 2.
  function automatic logic [1:0] pick_floor(input logic [2:0] avail, input logic [1:0] start);
    logic [1:0] pick;
    logic       found;
    int         idx;
    pick  = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idx = (int'(start) + i) % 3;
      if (!found && avail[idx]) begin
        pick  = 2'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign avail_s[0] = (occ_q[0] != CAP_C);
  assign avail_s[1] = (occ_q[1] != CAP_C);
  assign avail_s[2] = (occ_q[2] != CAP_C);
  assign full_s     = ~|avail_s;
  assign pick_s     = pick_floor(avail_s, start_s);

`ifdef FLOOR_ROUND_ROBIN_EN
  logic [1:0] ptr_q, ptr_d;

  assign start_s = (ptr_q == 2'd2) ? 2'd0 : (ptr_q + 2'd1);

  // Rotation pointer follows the floor of each granted entry.
  always_comb begin
    ptr_d = ptr_q;
    if (entry_ack_d) begin
      ptr_d = floor_d;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer starts at floor 2 so the first allocation lands on floor 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 2'd2;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign start_s = 2'd0;
`endif

  // Exit is legal only for a real floor that currently holds a car.
  always_comb begin
    exit_ok_s = 1'b0;
    case (bus.exit_floor)
      2'd0:    exit_ok_s = (occ_q[0] != CNT_ZERO_C);
      2'd1:    exit_ok_s = (occ_q[1] != CNT_ZERO_C);
      2'd2:    exit_ok_s = (occ_q[2] != CNT_ZERO_C);
      default: exit_ok_s = 1'b0;
    endcase
  end

  // Next-state, occupancy update and response pulses.
  always_comb begin
    state_d      = state_q;
    occ_d        = occ_q;
    floor_d      = floor_q;
    bar_cnt_d    = bar_cnt_q;
    barrier_d    = 1'b0;
    entry_ack_d  = 1'b0;
    entry_nack_d = 1'b0;
    exit_ack_d   = 1'b0;
    exit_err_d   = 1'b0;
    svc_exit_d   = svc_exit_q;
    case (state_q)
      IDLE: begin
        if (bus.exit_req) begin
          state_d    = EXIT;
          svc_exit_d = 1'b1;
        end else if (bus.entry_req) begin
          state_d    = ENTRY;
          svc_exit_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      ENTRY: begin
        if (!full_s) begin
          for (int i = 0; i < 3; i++) begin
            if (i == int'(pick_s)) begin
              occ_d[i] = occ_q[i] + CNT_ONE_C;
            end else begin
              occ_d[i] = occ_q[i];
            end
          end
          floor_d     = pick_s;
          entry_ack_d = 1'b1;
          bar_cnt_d   = BAR_LOAD_C;
          state_d     = OPEN;
        end else begin
          entry_nack_d = 1'b1;
          state_d      = RELEASE;
        end
      end
      EXIT: begin
        if (exit_ok_s) begin
          for (int i = 0; i < 3; i++) begin
            if (i == int'(bus.exit_floor)) begin
              occ_d[i] = occ_q[i] - CNT_ONE_C;
            end else begin
              occ_d[i] = occ_q[i];
            end
          end
          exit_ack_d = 1'b1;
          bar_cnt_d  = BAR_LOAD_C;
          state_d    = OPEN;
        end else begin
          exit_err_d = 1'b1;
          state_d    = RELEASE;
        end
      end
      OPEN: begin
        if (bar_cnt_q != BAR_ZERO_C) begin
          barrier_d = 1'b1;
          bar_cnt_d = bar_cnt_q - BAR_ONE_C;
        end else begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        // Hold here until the serviced request drops so it is never serviced twice.
        if (svc_exit_q ? !bus.exit_req : !bus.entry_req) begin
          state_d = IDLE;
        end else begin
          state_d = RELEASE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, occupancy and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      occ_q[0]     <= CNT_ZERO_C;
      occ_q[1]     <= CNT_ZERO_C;
      occ_q[2]     <= CNT_ZERO_C;
      floor_q      <= 2'd0;
      bar_cnt_q    <= BAR_ZERO_C;
      barrier_q    <= 1'b0;
      entry_ack_q  <= 1'b0;
      entry_nack_q <= 1'b0;
      exit_ack_q   <= 1'b0;
      exit_err_q   <= 1'b0;
      svc_exit_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      occ_q[0]     <= occ_d[0];
      occ_q[1]     <= occ_d[1];
      occ_q[2]     <= occ_d[2];
      floor_q      <= floor_d;
      bar_cnt_q    <= bar_cnt_d;
      barrier_q    <= barrier_d;
      entry_ack_q  <= entry_ack_d;
      entry_nack_q <= entry_nack_d;
      exit_ack_q   <= exit_ack_d;
      exit_err_q   <= exit_err_d;
      svc_exit_q   <= svc_exit_d;
    end
  end

  assign bus.entry_ack    = entry_ack_q;
  assign bus.entry_nack   = entry_nack_q;
  assign bus.exit_ack     = exit_ack_q;
  assign bus.exit_err     = exit_err_q;
  assign bus.barrier_open = barrier_q;
  assign bus.floor        = floor_q;
  assign bus.full         = full_s;
  assign bus.occ0         = occ_q[0];
  assign bus.occ1         = occ_q[1];
  assign bus.occ2         = occ_q[2];
endmodule

// File: tb/tb_parking_floor_allocator.sv
// Self-checking bench for parking_floor_allocator: directed scenarios plus a randomized
// entry/exit mix, all compared against a slot-count model of the car park.
module tb_parking_floor_allocator;
  localparam int CAP = 2;
  localparam int BC  = 3;
  localparam int CW  = $clog2(CAP + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  parking_floor_allocator_if #(.CNT_W(CW)) bus();

  parking_floor_allocator #(.CAPACITY(CAP), .BARRIER_CYCLES(BC)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int m_occ [3];
  int m_ptr;
  int m_floor;

  int o_eack, o_enack, o_xack, o_xerr;
  int o_bar, o_bar_runs, o_bar_first, o_pulse_idx, o_floor;

  function automatic int dut_occ(input int f);
    case (f)
      0:       return int'(bus.occ0);
      1:       return int'(bus.occ1);
      default: return int'(bus.occ2);
    endcase
  endfunction

  // Floor a new car should get, or -1 when every floor is at capacity.
  function automatic int model_pick();
    int start;
    int f;
    start = 0;
`ifdef FLOOR_ROUND_ROBIN_EN
    start = (m_ptr + 1) % 3;
`endif
    for (int k = 0; k < 3; k++) begin
      f = (start + k) % 3;
      if (m_occ[f] < CAP) return f;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_occ[i] = 0;
    m_ptr   = 2;
    m_floor = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.entry_req  = 1'b0;
    bus.exit_req   = 1'b0;
    bus.exit_floor = 2'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Drive request levels for a fixed number of cycles and record what the DUT does.
  task automatic service(input logic en, input logic ex, input logic [1:0] ef, input int cycles);
    logic prev_bar;
    bus.entry_req  = en;
    bus.exit_req   = ex;
    bus.exit_floor = ef;
    o_eack = 0; o_enack = 0; o_xack = 0; o_xerr = 0;
    o_bar = 0; o_bar_runs = 0; o_bar_first = -1; o_pulse_idx = -1; o_floor = -1;
    prev_bar = bus.barrier_open;
    for (int i = 1; i <= cycles; i++) begin
      @(negedge clk);
      if (bus.entry_ack)  begin o_eack++;  o_floor = int'(bus.floor); end
      if (bus.entry_nack) o_enack++;
      if (bus.exit_ack)   o_xack++;
      if (bus.exit_err)   o_xerr++;
      if ((bus.entry_ack || bus.entry_nack || bus.exit_ack || bus.exit_err) && o_pulse_idx < 0)
        o_pulse_idx = i;
      if (bus.barrier_open) begin
        o_bar++;
        if (o_bar_first < 0) o_bar_first = i;
        if (!prev_bar) o_bar_runs++;
      end
      prev_bar = bus.barrier_open;
    end
  endtask

  task automatic idle_gap(input int n);
    bus.entry_req = 1'b0;
    bus.exit_req  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    for (int f = 0; f < 3; f++) begin
      n_checks++;
      if (dut_occ(f) !== 0) begin n_fail++; $display("FAIL reset_occ%0d got %0d want 0", f, dut_occ(f)); end
    end
    n_checks++;
    if ({bus.floor, bus.full, bus.barrier_open} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_outputs floor=%0d full=%0b bar=%0b want 0", bus.floor, bus.full, bus.barrier_open);
    end
    n_checks++;
    if ({bus.entry_ack, bus.entry_nack, bus.exit_ack, bus.exit_err} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_pulses got %b want 0000", {bus.entry_ack, bus.entry_nack, bus.exit_ack, bus.exit_err});
    end
  endtask

  task automatic test_single_entry();
    do_reset();
    service(1'b1, 1'b0, 2'd0, 20);
    n_checks++;
    if (o_eack != 1 || o_enack != 0 || o_xack != 0 || o_xerr != 0) begin
      n_fail++; $display("FAIL single_pulses eack=%0d enack=%0d xack=%0d xerr=%0d want 1 0 0 0", o_eack, o_enack, o_xack, o_xerr);
    end
    n_checks++;
    if (o_pulse_idx != 2) begin n_fail++; $display("FAIL single_ack_latency got %0d want 2", o_pulse_idx); end
    n_checks++;
    if (o_floor != 0 || dut_occ(0) != 1) begin
      n_fail++; $display("FAIL single_floor_occ floor=%0d occ0=%0d want 0 1", o_floor, dut_occ(0));
    end
    n_checks++;
    if (o_bar != BC || o_bar_runs != 1 || o_bar_first != 3) begin
      n_fail++; $display("FAIL single_barrier cycles=%0d runs=%0d first=%0d want %0d 1 3", o_bar, o_bar_runs, o_bar_first, BC);
    end
    idle_gap(2);
  endtask

  task automatic test_fill();
    int ef;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      ef = model_pick();
      service(1'b1, 1'b0, 2'd0, 8);
      m_occ[ef]++; m_ptr = ef; m_floor = ef;
      n_checks++;
      if (o_eack != 1 || o_enack != 0 || o_floor != ef) begin
        n_fail++; $display("FAIL fill_%0d eack=%0d enack=%0d floor=%0d want 1 0 %0d", k, o_eack, o_enack, o_floor, ef);
      end
      n_checks++;
      if (dut_occ(ef) != m_occ[ef] || o_bar != BC) begin
        n_fail++; $display("FAIL fill_occ_%0d occ=%0d bar=%0d want %0d %0d", k, dut_occ(ef), o_bar, m_occ[ef], BC);
      end
      idle_gap(2);
    end
    n_checks++;
    if (bus.full !== 1'b1) begin n_fail++; $display("FAIL fill_full got %0b want 1", bus.full); end
    service(1'b1, 1'b0, 2'd0, 8);
    n_checks++;
    if (o_enack != 1 || o_eack != 0 || o_bar != 0) begin
      n_fail++; $display("FAIL full_nack enack=%0d eack=%0d bar=%0d want 1 0 0", o_enack, o_eack, o_bar);
    end
    for (int f = 0; f < 3; f++) begin
      n_checks++;
      if (dut_occ(f) != CAP) begin n_fail++; $display("FAIL full_occ%0d got %0d want %0d", f, dut_occ(f), CAP); end
    end
    n_checks++;
    if (int'(bus.floor) != m_floor) begin n_fail++; $display("FAIL full_floor got %0d want %0d", bus.floor, m_floor); end
    idle_gap(2);
  endtask

  task automatic test_priority();
    int ef;
    do_reset();
    service(1'b1, 1'b0, 2'd0, 8);
    m_occ[0] = 1; m_ptr = 0; m_floor = 0;
    idle_gap(2);
    service(1'b1, 1'b1, 2'd0, 10);
    m_occ[0] = 0;
    n_checks++;
    if (o_xack != 1 || o_eack != 0 || dut_occ(0) != 0) begin
      n_fail++; $display("FAIL prio_exit_first xack=%0d eack=%0d occ0=%0d want 1 0 0", o_xack, o_eack, dut_occ(0));
    end
    ef = model_pick();
    service(1'b1, 1'b0, 2'd0, 10);
    m_occ[ef]++; m_ptr = ef; m_floor = ef;
    n_checks++;
    if (o_eack != 1 || o_floor != ef || dut_occ(ef) != m_occ[ef]) begin
      n_fail++; $display("FAIL prio_entry_after eack=%0d floor=%0d occ=%0d want 1 %0d %0d", o_eack, o_floor, dut_occ(ef), ef, m_occ[ef]);
    end
    idle_gap(2);
  endtask

  task automatic test_bad_exit();
    do_reset();
    service(1'b1, 1'b0, 2'd0, 8);
    m_occ[0] = 1; m_ptr = 0; m_floor = 0;
    idle_gap(2);
    service(1'b0, 1'b1, 2'd1, 8);
    n_checks++;
    if (o_xerr != 1 || o_xack != 0 || o_bar != 0 || o_pulse_idx != 2) begin
      n_fail++; $display("FAIL bad_exit_empty xerr=%0d xack=%0d bar=%0d idx=%0d want 1 0 0 2", o_xerr, o_xack, o_bar, o_pulse_idx);
    end
    idle_gap(2);
    service(1'b0, 1'b1, 2'd3, 8);
    n_checks++;
    if (o_xerr != 1 || o_xack != 0 || o_bar != 0) begin
      n_fail++; $display("FAIL bad_exit_floor3 xerr=%0d xack=%0d bar=%0d want 1 0 0", o_xerr, o_xack, o_bar);
    end
    n_checks++;
    if (dut_occ(0) != 1 || dut_occ(1) != 0 || dut_occ(2) != 0) begin
      n_fail++; $display("FAIL bad_exit_occ got %0d %0d %0d want 1 0 0", dut_occ(0), dut_occ(1), dut_occ(2));
    end
    idle_gap(2);
  endtask

  task automatic test_reset_mid_open();
    do_reset();
    service(1'b1, 1'b0, 2'd0, 3);
    n_checks++;
    if (o_bar != 1 || o_eack != 1) begin n_fail++; $display("FAIL midopen_setup bar=%0d eack=%0d want 1 1", o_bar, o_eack); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.barrier_open !== 1'b0 || dut_occ(0) != 0 || bus.full !== 1'b0) begin
      n_fail++; $display("FAIL midopen_reset bar=%0b occ0=%0d full=%0b want 0 0 0", bus.barrier_open, dut_occ(0), bus.full);
    end
    rst = 1'b0;
    bus.entry_req = 1'b0;
    model_reset();
    @(negedge clk);
    service(1'b1, 1'b0, 2'd0, 8);
    n_checks++;
    if (o_eack != 1 || o_pulse_idx != 2 || o_floor != 0 || dut_occ(0) != 1) begin
      n_fail++; $display("FAIL midopen_idle eack=%0d idx=%0d floor=%0d occ0=%0d want 1 2 0 1", o_eack, o_pulse_idx, o_floor, dut_occ(0));
    end
    m_occ[0] = 1; m_ptr = 0; m_floor = 0;
    idle_gap(2);
  endtask

  task automatic test_random();
    logic       is_exit;
    logic [1:0] ef;
    int         pick, we, wen, wx, wxe, wbar;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      is_exit = ($urandom_range(0, 9) < 4);
      ef = 2'($urandom_range(0, 3));
      we = 0; wen = 0; wx = 0; wxe = 0; wbar = 0;
      if (is_exit) begin
        if (int'(ef) <= 2 && m_occ[int'(ef)] > 0) begin
          m_occ[int'(ef)]--; wx = 1; wbar = BC;
        end else begin
          wxe = 1;
        end
      end else begin
        pick = model_pick();
        if (pick >= 0) begin
          m_occ[pick]++; m_ptr = pick; m_floor = pick; we = 1; wbar = BC;
        end else begin
          wen = 1;
        end
      end
      service(~is_exit, is_exit, ef, 8);
      n_checks++;
      if (o_eack != we || o_enack != wen || o_xack != wx || o_xerr != wxe || o_bar != wbar) begin
        n_fail++;
        $display("FAIL rand_%0d resp eack/enack/xack/xerr/bar=%0d/%0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d/%0d",
                 t, o_eack, o_enack, o_xack, o_xerr, o_bar, we, wen, wx, wxe, wbar);
      end
      n_checks++;
      if (dut_occ(0) != m_occ[0] || dut_occ(1) != m_occ[1] || dut_occ(2) != m_occ[2] || int'(bus.floor) != m_floor) begin
        n_fail++;
        $display("FAIL rand_%0d state occ=%0d,%0d,%0d floor=%0d want %0d,%0d,%0d floor=%0d",
                 t, dut_occ(0), dut_occ(1), dut_occ(2), bus.floor, m_occ[0], m_occ[1], m_occ[2], m_floor);
      end
      n_checks++;
      if (bus.full !== ((m_occ[0] == CAP) && (m_occ[1] == CAP) && (m_occ[2] == CAP))) begin
        n_fail++; $display("FAIL rand_%0d full got %0b", t, bus.full);
      end
      idle_gap(2);
    end
  endtask

`ifdef FLOOR_ROUND_ROBIN_EN
  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      service(1'b1, 1'b0, 2'd0, 8);
      n_checks++;
      if (o_eack != 1 || o_floor != k || dut_occ(k) != 1) begin
        n_fail++; $display("FAIL rr_%0d eack=%0d floor=%0d occ=%0d want 1 %0d 1", k, o_eack, o_floor, dut_occ(k), k);
      end
      idle_gap(2);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_entry();
    test_fill();
    test_priority();
    test_bad_exit();
    test_reset_mid_open();
    test_random();
`ifdef FLOOR_ROUND_ROBIN_EN
    test_round_robin();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
